// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester and transmitter handshake bundle for uart_tx_scheduler
// master: producers/transmitter side (drives req_valid, req_data, tx_done)
// slave : scheduler side (drives req_ready, tx_start, tx_data, grant_id, busy, timeout_err)
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int GW = $clog2(N_REQ);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               timeout_err;
  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );
  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART byte transmitter with idle gap and completion timeout
// clk, reset_n (async, active-low), br_tick (baud tick); bus: uart_tx_scheduler_if.slave
module uart_tx_scheduler #(
  parameter int N_REQ         = 4,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic br_tick,
  uart_tx_scheduler_if.slave bus
);
  localparam int GW   = $clog2(N_REQ);
  localparam int MAXT = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  typedef enum logic [1:0] {ARB, LOAD, SEND, GAP} state_t;
  state_t          state, state_n;
  logic [GW-1:0]   rr_ptr, win, grant_id;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      tx_data;
  logic            any, accept, timeout;
  assign any    = |bus.req_valid;
  assign accept = state == ARB && any;
  // First valid index at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req_valid[(int'(rr_ptr) + i) % N_REQ]) win = GW'((int'(rr_ptr) + i) % N_REQ);
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    timeout = 1'b0;
    case (state)
      ARB:  state_n = any ? LOAD : ARB;
      LOAD: begin
        state_n = SEND;
        cnt_n   = '0;
      end
      // tx_done takes priority over a terminal tick arriving in the same cycle
      SEND: if (bus.tx_done) begin
        state_n = (GAP_TICKS == 0) ? ARB : GAP;
        cnt_n   = '0;
      end else if (br_tick) begin
        state_n = (cnt == TO_LAST) ? ARB : SEND;
        cnt_n   = (cnt == TO_LAST) ? '0 : cnt + CW'(1);
        timeout = cnt == TO_LAST;
      end
      GAP: if (br_tick) begin
        state_n = (cnt == GAP_LAST) ? ARB : GAP;
        cnt_n   = (cnt == GAP_LAST) ? '0 : cnt + CW'(1);
      end
      default: state_n = ARB;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB;
      cnt      <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        tx_data  <= bus.req_data[8*win +: 8];
        grant_id <= win;
        rr_ptr   <= (win == GW'(N_REQ - 1)) ? '0 : win + GW'(1);
      end
    end
  end
  // req_ready is gated by reset_n so it stays low while reset is asserted with requests pending
  assign bus.req_ready   = (accept && reset_n) ? N_REQ'(1) << win : '0;
  assign bus.tx_start    = state == LOAD;
  assign bus.busy        = state != ARB;
  assign bus.timeout_err = timeout;
  assign bus.tx_data     = tx_data;
  assign bus.grant_id    = grant_id;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler (gap=2 and gap=0 instances)
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic br_tick = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  uart_tx_scheduler_if #(.N_REQ(4)) a ();
  uart_tx_scheduler_if #(.N_REQ(4)) b ();
  uart_tx_scheduler #(.N_REQ(4), .GAP_TICKS(2), .TIMEOUT_TICKS(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .br_tick(br_tick), .bus(a)
  );
  uart_tx_scheduler #(.N_REQ(4), .GAP_TICKS(0), .TIMEOUT_TICKS(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .br_tick(br_tick), .bus(b)
  );
  always #5 clk = ~clk;
  task automatic pulse_tick();
    @(negedge clk) br_tick = 1'b1;
    @(negedge clk) br_tick = 1'b0;
  endtask
  task automatic pulse_done();
    @(negedge clk) a.tx_done = 1'b1;
    @(negedge clk) a.tx_done = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    br_tick = 1'b0;
    a.req_valid = '0; a.tx_done = 1'b0;
    b.req_valid = '0; b.tx_done = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask
  // Called at a negedge; waits (bounded) for an accept on dut0, then checks the start cycle.
  task automatic accept(input int k, input logic [7:0] d, input logic [3:0] nv, output int waited);
    logic [3:0] m;
    m = 4'(1 << k);
    waited = 0;
    br_tick = 1'b0;
    a.tx_done = 1'b0;
    #1;
    while (a.req_ready == 4'b0 && waited < 40) begin
      @(negedge clk);
      br_tick = 1'b0;
      a.tx_done = 1'b0;
      #1;
      waited++;
    end
    n_chk++; if (a.req_ready !== m) $display("FAIL accept_ready got=%b exp=%b", a.req_ready, m); else n_pass++;
    @(negedge clk);
    a.req_valid = nv;
    #1;
    n_chk++; if (a.tx_start !== 1'b1) $display("FAIL accept_tx_start got=%b exp=1", a.tx_start); else n_pass++;
    n_chk++; if (a.tx_data !== d) $display("FAIL accept_tx_data got=%h exp=%h", a.tx_data, d); else n_pass++;
    n_chk++; if (a.grant_id !== 2'(k)) $display("FAIL accept_grant_id got=%0d exp=%0d", a.grant_id, k); else n_pass++;
    n_chk++; if (a.req_ready !== 4'b0) $display("FAIL accept_ready_drop got=%b exp=0000", a.req_ready); else n_pass++;
  endtask
  task automatic do_frame(input int k, input logic [7:0] d, input int nt, input logic [3:0] nv);
    int w;
    accept(k, d, nv, w);
    repeat (nt) pulse_tick();
    pulse_done();
    #1;
    n_chk++; if (a.busy !== 1'b1) $display("FAIL frame_gap_busy got=%b exp=1", a.busy); else n_pass++;
    pulse_tick();
    #1;
    n_chk++; if (a.req_ready !== 4'b0) $display("FAIL frame_gap_hold got=%b exp=0000", a.req_ready); else n_pass++;
    pulse_tick();
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    a.req_valid = 4'b1111; a.req_data = '0; a.tx_done = 1'b0;
    b.req_valid = '0; b.req_data = '0; b.tx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (a.req_ready !== 4'b0) $display("FAIL rst_ready got=%b exp=0000", a.req_ready); else n_pass++;
    n_chk++; if (a.tx_start !== 1'b0) $display("FAIL rst_tx_start got=%b exp=0", a.tx_start); else n_pass++;
    n_chk++; if (a.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", a.busy); else n_pass++;
    n_chk++; if (a.timeout_err !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", a.timeout_err); else n_pass++;
    n_chk++; if (a.grant_id !== 2'd0) $display("FAIL rst_grant got=%0d exp=0", a.grant_id); else n_pass++;
    n_chk++; if (a.tx_data !== 8'h00) $display("FAIL rst_tx_data got=%h exp=00", a.tx_data); else n_pass++;
    do_reset();
  endtask
  task automatic test_single();
    do_reset();
    a.req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    a.req_valid = 4'b0001;
    do_frame(0, 8'hA5, 10, 4'b0000);
    #1;
    n_chk++; if (a.busy !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", a.busy); else n_pass++;
  endtask
  task automatic test_round_robin();
    do_reset();
    a.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    a.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) do_frame(i % 4, 8'h10 + 8'(i % 4), 1, 4'b1111);
  endtask
  task automatic test_rr_ptr();
    do_reset();
    a.req_data = {8'h33, 8'h22, 8'h11, 8'h00};
    a.req_valid = 4'b0010;
    do_frame(1, 8'h11, 0, 4'b1011);
    do_frame(3, 8'h33, 0, 4'b1011);
    do_frame(0, 8'h00, 0, 4'b0000);
  endtask
  task automatic test_timeout();
    int w;
    do_reset();
    a.req_data = {8'h00, 8'hC3, 8'h00, 8'hA5};
    a.req_valid = 4'b0001;
    accept(0, 8'hA5, 4'b0100, w);
    repeat (15) pulse_tick();
    #1;
    n_chk++; if (a.busy !== 1'b1) $display("FAIL to_busy15 got=%b exp=1", a.busy); else n_pass++;
    @(negedge clk) br_tick = 1'b1;
    #1;
    n_chk++; if (a.timeout_err !== 1'b1) $display("FAIL to_err16 got=%b exp=1", a.timeout_err); else n_pass++;
    @(negedge clk);
    br_tick = 1'b0;
    #1;
    n_chk++; if (a.timeout_err !== 1'b0) $display("FAIL to_err_pulse got=%b exp=0", a.timeout_err); else n_pass++;
    n_chk++; if (a.busy !== 1'b0) $display("FAIL to_busy_arb got=%b exp=0", a.busy); else n_pass++;
    accept(2, 8'hC3, 4'b0000, w);
    n_chk++; if (w !== 0) $display("FAIL to_next_latency got=%0d exp=0", w); else n_pass++;
  endtask
  task automatic test_reset_mid_frame();
    int w;
    do_reset();
    a.req_data = {8'h00, 8'h66, 8'h77, 8'h00};
    a.req_valid = 4'b0010;
    accept(1, 8'h77, 4'b0110, w);
    repeat (2) pulse_tick();
    @(negedge clk) reset_n = 1'b0;
    #1;
    n_chk++; if (a.busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", a.busy); else n_pass++;
    n_chk++; if (a.req_ready !== 4'b0) $display("FAIL mid_rst_ready got=%b exp=0000", a.req_ready); else n_pass++;
    n_chk++; if (a.grant_id !== 2'd0) $display("FAIL mid_rst_grant got=%0d exp=0", a.grant_id); else n_pass++;
    n_chk++; if (a.tx_data !== 8'h00) $display("FAIL mid_rst_tx_data got=%h exp=00", a.tx_data); else n_pass++;
    @(negedge clk) reset_n = 1'b1;
    accept(1, 8'h77, 4'b0000, w);
  endtask
  task automatic test_done_vs_timeout();
    int w;
    do_reset();
    a.req_data = {8'h00, 8'h00, 8'h5A, 8'hA5};
    b.req_data = {8'h00, 8'h00, 8'h5A, 8'hA5};
    a.req_valid = 4'b0001;
    b.req_valid = 4'b0001;
    accept(0, 8'hA5, 4'b0010, w);
    b.req_valid = 4'b0010;
    repeat (15) pulse_tick();
    @(negedge clk);
    br_tick = 1'b1; a.tx_done = 1'b1; b.tx_done = 1'b1;
    #1;
    n_chk++; if (a.timeout_err !== 1'b0) $display("FAIL tie_err_gap2 got=%b exp=0", a.timeout_err); else n_pass++;
    n_chk++; if (b.timeout_err !== 1'b0) $display("FAIL tie_err_gap0 got=%b exp=0", b.timeout_err); else n_pass++;
    @(negedge clk);
    br_tick = 1'b0; a.tx_done = 1'b0; b.tx_done = 1'b0;
    #1;
    n_chk++; if (a.busy !== 1'b1) $display("FAIL tie_gap_busy got=%b exp=1", a.busy); else n_pass++;
    n_chk++; if (a.req_ready !== 4'b0) $display("FAIL tie_gap_ready got=%b exp=0000", a.req_ready); else n_pass++;
    n_chk++; if (b.req_ready !== 4'b0010) $display("FAIL gap0_ready got=%b exp=0010", b.req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (b.tx_start !== 1'b1) $display("FAIL gap0_tx_start got=%b exp=1", b.tx_start); else n_pass++;
    n_chk++; if (b.tx_data !== 8'h5A) $display("FAIL gap0_tx_data got=%h exp=5a", b.tx_data); else n_pass++;
    n_chk++; if (b.grant_id !== 2'd1) $display("FAIL gap0_grant got=%0d exp=1", b.grant_id); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_ptr();
    test_timeout();
    test_reset_mid_frame();
    test_done_vs_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
